ql_bank_config_ctrl: RTL and testbench
======================================

// Module: ql_bank_config_ctrl
// PURPOSE
//   Sequences loading of a memory-bank configuration region (bit-lines/word-lines) from a streamed
//   bitstream. Each accepted word is one WL row: driven on bl, then strobed into that row by a
//   one-hot wl pulse. Holds fabric_resetn low throughout loading; releases it after the last row
//   plus a settle delay. Sits between the bitstream source and fpga_top bl_config_region_0 /
//   wl_config_region_0 / global_resetn.
// PARAMETERS
//   BL_WIDTH       514  bits per row (width of bl / cfg_data)
//   WL_COUNT       407  number of rows (width of wl); must be >= 1
//   SETUP_CYCLES   1    cycles bl is stable before wl asserts; must be >= 1
//   PULSE_CYCLES   2    cycles wl[row] is held high; must be >= 1
//   RELEASE_DELAY  4    cycles after the last row before fabric_resetn rises; must be >= 1
// PORTS
//   clk            in   1                    single clock, rising edge
//   reset          in   1                    synchronous, active-high
//   start          in   1                    begin a load; sampled only in IDLE
//   abort          in   1                    cancel an in-progress load
//   cfg_data       in   BL_WIDTH             row data; bit i drives bl[i]
//   cfg_valid      in   1                    cfg_data valid
//   cfg_ready      out  1                    controller accepts cfg_data
//   bl             out  [0:BL_WIDTH-1]       bit-line drive
//   wl             out  [0:WL_COUNT-1]       word-line strobes; wl[0] = row 0
//   row_idx        out  $clog2(WL_COUNT)     current row (min width 1)
//   busy           out  1                    load in progress
//   done           out  1                    sticky: last load completed
//   fabric_resetn  out  1                    fabric reset, active-low
// BEHAVIOUR
//   Reset: state=IDLE; bl=0, wl=0, cfg_ready=0, row_idx=0, busy=0, done=0, fabric_resetn=0.
//   All outputs are registered.
//   Handshake: transfer on cfg_valid&cfg_ready. cfg_ready=1 only in LOAD. cfg_valid in any other
//     state is ignored and not consumed. cfg_data is sampled only on a transfer.
//   States:
//     IDLE: start=1 -> LOAD. Next cycle: busy=1, done=0, fabric_resetn=0, row_idx=0.
//     LOAD: wait for transfer. On transfer: bl<=cfg_data, -> SETUP.
//     SETUP: wl=0, bl stable for SETUP_CYCLES cycles -> PULSE.
//     PULSE: wl = one-hot at row_idx for exactly PULSE_CYCLES cycles -> HOLD.
//     HOLD (1 cycle): wl=0, bl unchanged.
//       If row_idx==WL_COUNT-1 -> RELEASE.
//       Else row_idx++ -> LOAD.
//     RELEASE: bl=0, wl=0 for RELEASE_DELAY cycles. Then fabric_resetn=1, done=1, busy=0,
//       row_idx=0 -> IDLE.
//   Per-row latency with cfg_valid held high: 1+SETUP_CYCLES+PULSE_CYCLES+1 cycles
//     (5 at defaults). wl[r] first rises 1+SETUP_CYCLES cycles after the transfer edge.
//   wl is never multi-hot, and is never high while bl is changing.
//   start while busy: ignored.
//   start in IDLE after done: restarts the load. done and fabric_resetn fall the next cycle.
//   abort in any non-IDLE state: next cycle -> IDLE with bl=0, wl=0, cfg_ready=0, busy=0,
//     done=0, fabric_resetn=0, row_idx=0. Any partial word is discarded.
//   abort in IDLE: no effect. abort and start asserted together in IDLE: start wins.
//   reset overrides everything, including mid-pulse: wl=0 the next cycle.
// TESTING  (BL_WIDTH=8, WL_COUNT=4, SETUP=1, PULSE=2, RELEASE=4 unless noted)
//   1. Assert reset 3 cycles -> all outputs 0, cfg_ready=0, state IDLE; cfg_valid=1 is not consumed.
//   2. start, then stream 8'hA5, 8'h3C, 8'hFF, 8'h01 with valid held high ->
//        wl=1000,0100,0010,0001, each high exactly 2 cycles, bl equals the matching word;
//        wl rises 2 cycles after each transfer; 5 cycles per row;
//        fabric_resetn=1 and done=1 exactly 5 cycles after the last HOLD (4 RELEASE cycles
//        plus the IDLE transition); busy=0.
//   3. Same stream with 3-cycle valid gaps between words -> wl stays 0 during gaps;
//        no row skipped or repeated; final strobe pattern is identical to test 2.
//   4. abort during the 2nd PULSE cycle of row 2 -> next cycle wl=0, bl=0, busy=0,
//        done=0, fabric_resetn=0. A fresh start plus 4 words then completes as in test 2.
//   5. start pulsed during row 1 -> ignored: row_idx continues 1->2->3, single done.
//   6. After done, start -> done=0 and fabric_resetn=0 the next cycle; a full reload then
//        reasserts both. WL_COUNT=1: a single pulse on wl[0], then RELEASE.

Source files
------------

// File: rtl/ql_bank_config_ctrl.sv
// Bank configuration loader: streams one bit-line row per accepted word,
// strobes the matching word-line, and holds the fabric in reset until the
// whole region is written and a settle delay has elapsed.
module ql_bank_config_ctrl #(
    parameter int BL_WIDTH      = 514,
    parameter int WL_COUNT      = 407,
    parameter int SETUP_CYCLES  = 1,
    parameter int PULSE_CYCLES  = 2,
    parameter int RELEASE_DELAY = 4,
    localparam int ROW_W        = (WL_COUNT > 1) ? $clog2(WL_COUNT) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [BL_WIDTH-1:0] cfg_data,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [0:BL_WIDTH-1] bl,
    output logic [0:WL_COUNT-1] wl,
    output logic [ROW_W-1:0]    row_idx,
    output logic                busy,
    output logic                done,
    output logic                fabric_resetn
);

    // One down-counter serves the setup, pulse and release phases, so it is
    // sized for the longest of the three.
    localparam int CNT_MAX_SP = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_SP > RELEASE_DELAY) ? CNT_MAX_SP : RELEASE_DELAY;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LOAD = CNT_W'(RELEASE_DELAY - 1);
    localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(WL_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_RELEASE
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [ROW_W-1:0]    row_n;
    logic [0:BL_WIDTH-1] bl_n;
    logic [0:WL_COUNT-1] wl_n;
    logic                ready_n;
    logic                busy_n;
    logic                done_n;
    logic                resetn_n;

    // Register state and every output so the array sees glitch-free drives.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            row_idx       <= '0;
            bl            <= '0;
            wl            <= '0;
            cfg_ready     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fabric_resetn <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            row_idx       <= row_n;
            bl            <= bl_n;
            wl            <= wl_n;
            cfg_ready     <= ready_n;
            busy          <= busy_n;
            done          <= done_n;
            fabric_resetn <= resetn_n;
        end
    end

    // Next-state and next-output logic; abort from any active state wins last.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        row_n    = row_idx;
        bl_n     = bl;
        wl_n     = wl;
        ready_n  = cfg_ready;
        busy_n   = busy;
        done_n   = done;
        resetn_n = fabric_resetn;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_LOAD;
                    ready_n  = 1'b1;
                    busy_n   = 1'b1;
                    done_n   = 1'b0;
                    resetn_n = 1'b0;
                    row_n    = '0;
                end
            end

            S_LOAD: begin
                if (cfg_valid && cfg_ready) begin
                    // cfg_data bit i lands on bl[i]; the two vectors are
                    // declared with opposite ranges, so copy bit by bit.
                    for (int i = 0; i < BL_WIDTH; i++) begin
                        bl_n[i] = cfg_data[i];
                    end
                    ready_n = 1'b0;
                    cnt_n   = SETUP_LOAD;
                    state_n = S_SETUP;
                end
            end

            S_SETUP: begin
                if (cnt == '0) begin
                    state_n = S_PULSE;
                    cnt_n   = PULSE_LOAD;
                    for (int r = 0; r < WL_COUNT; r++) begin
                        wl_n[r] = (row_idx == ROW_W'(r));
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end

            S_PULSE: begin
                if (cnt == '0) begin
                    state_n = S_HOLD;
                    wl_n    = '0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end

            S_HOLD: begin
                // bl is still held here so the word-line edge never
                // coincides with a bit-line change.
                if (row_idx == LAST_ROW) begin
                    state_n = S_RELEASE;
                    cnt_n   = RELEASE_LOAD;
                    bl_n    = '0;
                end else begin
                    row_n   = row_idx + ROW_W'(1);
                    state_n = S_LOAD;
                    ready_n = 1'b1;
                end
            end

            S_RELEASE: begin
                if (cnt == '0) begin
                    state_n  = S_IDLE;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                    resetn_n = 1'b1;
                    row_n    = '0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (abort && (state != S_IDLE)) begin
            state_n  = S_IDLE;
            cnt_n    = '0;
            row_n    = '0;
            bl_n     = '0;
            wl_n     = '0;
            ready_n  = 1'b0;
            busy_n   = 1'b0;
            done_n   = 1'b0;
            resetn_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_ql_bank_config_ctrl.sv
// Scoreboard bench for ql_bank_config_ctrl: stimulus pushes expected strobes
// and completions, a negedge monitor pops them as the DUT produces them.
module tb_ql_bank_config_ctrl;

    localparam int BLW     = 8;
    localparam int WLC     = 4;
    localparam int SETUP   = 1;
    localparam int PULSE   = 2;
    localparam int REL     = 4;
    localparam int ROW_LAT = 1 + SETUP + PULSE + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            start;
    logic            abort;
    logic [BLW-1:0]  cfg_data;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [0:BLW-1]  bl;
    logic [0:WLC-1]  wl;
    logic [1:0]      row_idx;
    logic            busy;
    logic            done;
    logic            fabric_resetn;

    logic            s_start;
    logic            s_abort;
    logic [BLW-1:0]  s_data;
    logic            s_valid;
    logic            s_ready;
    logic [0:BLW-1]  s_bl;
    logic [0:0]      s_wl;
    logic [0:0]      s_row;
    logic            s_busy;
    logic            s_done;
    logic            s_frn;

    ql_bank_config_ctrl #(
        .BL_WIDTH(BLW), .WL_COUNT(WLC), .SETUP_CYCLES(SETUP),
        .PULSE_CYCLES(PULSE), .RELEASE_DELAY(REL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .bl(bl), .wl(wl), .row_idx(row_idx), .busy(busy), .done(done),
        .fabric_resetn(fabric_resetn)
    );

    ql_bank_config_ctrl #(
        .BL_WIDTH(BLW), .WL_COUNT(1), .SETUP_CYCLES(SETUP),
        .PULSE_CYCLES(PULSE), .RELEASE_DELAY(REL)
    ) dut_single (
        .clk(clk), .reset(reset), .start(s_start), .abort(s_abort),
        .cfg_data(s_data), .cfg_valid(s_valid), .cfg_ready(s_ready),
        .bl(s_bl), .wl(s_wl), .row_idx(s_row), .busy(s_busy), .done(s_done),
        .fabric_resetn(s_frn)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int             row;
        logic [BLW-1:0] data;
        int             cyc;
    } strobe_t;

    strobe_t sq[$];
    int      dq[$];
    int      m_row = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [0:BLW-1] to_bl(input logic [BLW-1:0] d);
        logic [0:BLW-1] v;
        for (int i = 0; i < BLW; i++) v[i] = d[i];
        return v;
    endfunction

    function automatic logic [0:WLC-1] row_hot(input int r);
        logic [0:WLC-1] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    logic           mon_en = 1'b0;
    logic [0:WLC-1] prev_wl;
    logic [0:BLW-1] prev_bl;
    logic           prev_done;
    int             plen;
    int             cur_row;
    bit             in_pulse;
    bit             abort_pend;
    bit             was_abort;
    strobe_t        me;
    int             md;

    initial begin
        in_pulse   = 0;
        abort_pend = 0;
        plen       = 0;
        cur_row    = 0;
        forever begin
            @(negedge clk);
            if (mon_en && !reset) begin
                was_abort = abort_pend;
                if (abort_pend) begin
                    chk("abort_idle", 64'({wl, bl, busy, done, fabric_resetn, cfg_ready, row_idx}), 64'(0));
                    abort_pend = 0;
                end
                chk("wl_onehot", 64'($countones(wl) <= 1), 64'(1));
                if (bl != prev_bl && !was_abort)
                    chk("wl_low_while_bl_moves", 64'({prev_wl, wl}), 64'(0));

                if (wl != '0 && prev_wl == '0) begin
                    if (sq.size() == 0) begin
                        chk("unexpected_strobe", 64'(wl), 64'(0));
                    end else begin
                        me = sq.pop_front();
                        chk("strobe_wl", 64'(wl), 64'(row_hot(me.row)));
                        chk("strobe_bl", 64'(bl), 64'(to_bl(me.data)));
                        chk("strobe_rise_cycle", 64'(cyc), 64'(me.cyc));
                        chk("strobe_row_idx", 64'(row_idx), 64'(me.row));
                        cur_row = me.row;
                    end
                    in_pulse = 1;
                    plen     = 1;
                end else if (wl != '0) begin
                    chk("wl_hold", 64'(wl), 64'(row_hot(cur_row)));
                    plen++;
                end else if (prev_wl != '0 && in_pulse) begin
                    chk("pulse_width", 64'(plen), 64'(PULSE));
                    in_pulse = 0;
                end

                if (sq.size() > 0 && cyc > sq[0].cyc) begin
                    chk("strobe_missing_by_cycle", 64'(cyc), 64'(sq[0].cyc));
                    void'(sq.pop_front());
                end

                if (done && !prev_done) begin
                    if (dq.size() == 0) begin
                        chk("unexpected_done", 64'(done), 64'(0));
                    end else begin
                        md = dq.pop_front();
                        chk("done_cycle", 64'(cyc), 64'(md));
                        chk("done_outputs", 64'({fabric_resetn, busy, cfg_ready, row_idx, wl, bl}),
                            64'({1'b1, 16'h0000}));
                    end
                end
                if (dq.size() > 0 && cyc > dq[0]) begin
                    chk("done_missing_by_cycle", 64'(cyc), 64'(dq[0]));
                    void'(dq.pop_front());
                end

                if (busy) chk("resetn_low_while_busy", 64'({fabric_resetn, done}), 64'(0));

                if (abort && busy) begin
                    abort_pend = 1;
                    in_pulse   = 0;
                end
            end
            prev_wl   = wl;
            prev_bl   = bl;
            prev_done = done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_start(input bit with_abort);
        start = 1'b1;
        abort = with_abort;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_next_cycle", 64'({busy, done, fabric_resetn, cfg_ready, row_idx}),
            64'({1'b1, 1'b0, 1'b0, 1'b1, 2'b00}));
        m_row = 0;
    endtask

    task automatic put_word(input logic [BLW-1:0] w, input int gap, input bit start_in_gap);
        int      waited;
        strobe_t e;
        waited    = 0;
        cfg_data  = w;
        cfg_valid = 1'b1;
        while (!cfg_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (!cfg_ready) begin
            chk("ready_timeout", 64'(cfg_ready), 64'(1));
            cfg_valid = 1'b0;
            return;
        end
        e.row  = m_row;
        e.data = w;
        e.cyc  = cyc + 1 + SETUP;
        sq.push_back(e);
        if (m_row == WLC - 1) begin
            dq.push_back(cyc + ROW_LAT + REL);
            m_row = 0;
        end else begin
            m_row++;
        end
        tick();
        if (gap > 0) begin
            cfg_valid = 1'b0;
            cfg_data  = 8'($urandom);
            repeat (gap) begin
                start = start_in_gap;
                tick();
            end
            start = 1'b0;
        end
    endtask

    task automatic stream(input logic [BLW-1:0] w0, input logic [BLW-1:0] w1,
                          input logic [BLW-1:0] w2, input logic [BLW-1:0] w3, input int gap);
        logic [BLW-1:0] ws[4];
        ws = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++)
            put_word(ws[i], (gap < 0) ? int'($urandom_range(0, 3)) : gap, 1'b0);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sq.size() != 0 || dq.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        chk("queues_drained", 64'(sq.size() + dq.size()), 64'(0));
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [BLW-1:0] sw;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = 8'h5A;
        s_start   = 1'b0;
        s_abort   = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({bl, wl, cfg_ready, row_idx, busy, done, fabric_resetn}), 64'(0));
        chk("reset_single", 64'({s_bl, s_wl, s_ready, s_row, s_busy, s_done, s_frn}), 64'(0));
        reset = 1'b0;
        prev_wl = '0;
        prev_bl = '0;
        prev_done = 1'b0;
        mon_en = 1'b1;
        repeat (3) begin
            tick();
            chk("valid_ignored_idle", 64'({cfg_ready, busy, bl}), 64'(0));
        end
        cfg_valid = 1'b0;

        // directed stream, valid held high
        do_start(1'b0);
        stream(8'hA5, 8'h3C, 8'hFF, 8'h01, 0);
        wait_idle();
        chk("after_load", 64'({done, fabric_resetn, busy}), 64'(3'b110));

        // same stream with 3-cycle gaps
        do_start(1'b0);
        stream(8'hA5, 8'h3C, 8'hFF, 8'h01, 3);
        wait_idle();

        // abort while idle does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle_noop", 64'({done, fabric_resetn, busy}), 64'(3'b110));

        // abort in the second pulse cycle of row 2
        do_start(1'b0);
        put_word(8'($urandom), 0, 1'b0);
        put_word(8'($urandom), 0, 1'b0);
        put_word(8'($urandom), 0, 1'b0);
        tick();
        tick();
        abort     = 1'b1;
        cfg_valid = 1'b0;
        tick();
        abort = 1'b0;
        sq.delete();
        dq.delete();
        m_row = 0;
        tick();
        chk("post_abort", 64'({done, fabric_resetn, busy, cfg_ready}), 64'(0));

        // start and abort together in idle: start wins, then a clean load
        do_start(1'b1);
        stream(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);
        wait_idle();

        // start pulsed during row 1 is ignored
        do_start(1'b0);
        put_word(8'($urandom), 0, 1'b0);
        put_word(8'($urandom), 4, 1'b1);
        put_word(8'($urandom), 0, 1'b0);
        put_word(8'($urandom), 0, 1'b0);
        cfg_valid = 1'b0;
        wait_idle();

        // reloads after done with random data and gaps
        for (int k = 0; k < 3; k++) begin
            do_start(1'b0);
            stream(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), -1);
            wait_idle();
            chk("reload_done", 64'({done, fabric_resetn, busy}), 64'(3'b110));
        end

        // single-row instance
        sw      = 8'($urandom);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("single_start", 64'({s_busy, s_done, s_frn, s_ready, s_row}), 64'(5'b10010));
        s_data  = sw;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chk("single_wl", 64'(s_wl), 64'((k >= 1 + SETUP && k <= SETUP + PULSE) ? 1 : 0));
            chk("single_bl", 64'(s_bl),
                64'((k <= SETUP + PULSE + 1) ? to_bl(sw) : 8'h00));
            chk("single_status", 64'({s_done, s_frn, s_busy}),
                64'((k >= ROW_LAT + REL) ? 3'b110 : 3'b001));
            tick();
        end

        tick();
        chk("queues_empty_end", 64'(sq.size() + dq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
